// File: rtl/mac_engine_nlane.sv
// ---------------------------------------------------------------------------
// mac_engine_nlane
//
// N-lane signed multiply-accumulate engine. A job is launched with start_i.
// It then accumulates len_i beats of lane-wise a*b products. Each beat is a
// joint handshake on the a and b operand streams. At the end the engine
// presents one N_LANES-wide result beat on the d stream. Each result lane is
// the accumulator arithmetically shifted right by shift_i. done_o pulses for
// one cycle after the result has been accepted.
//
// Optional feature macro: MAC_ENGINE_NLANE_SAT_EN
//   defined   : each shifted lane value is clamped to the signed OUT_WIDTH range
//   undefined : each shifted lane value is truncated to its low OUT_WIDTH bits
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   clear_i                synchronous soft clear (aborts job, no done_o)
//   start_i, len_i,        job start pulse (IDLE only); beats per job and
//   shift_i                result right shift, both latched at start
//   a_valid_i/a_ready_o/   operand stream a, N_LANES x DATA_WIDTH signed
//   a_data_i
//   b_valid_i/b_ready_o/   operand stream b, N_LANES x DATA_WIDTH signed
//   b_data_i
//   d_valid_o/d_ready_i/   result stream d, N_LANES x OUT_WIDTH signed
//   d_data_o
//   busy_o                 job in progress
//   done_o                 one-cycle pulse after the result is accepted
//   cnt_o                  beats accepted in the current job
// Lane i occupies bits [i*W +: W] of each packed data bus.
// ---------------------------------------------------------------------------
module mac_engine_nlane #(
  parameter int unsigned N_LANES    = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter int unsigned OUT_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            clear_i,
  input  logic                            start_i,
  input  logic [CNT_WIDTH-1:0]            len_i,
  input  logic [$clog2(ACC_WIDTH)-1:0]    shift_i,
  input  logic                            a_valid_i,
  output logic                            a_ready_o,
  input  logic [N_LANES*DATA_WIDTH-1:0]   a_data_i,
  input  logic                            b_valid_i,
  output logic                            b_ready_o,
  input  logic [N_LANES*DATA_WIDTH-1:0]   b_data_i,
  output logic                            d_valid_o,
  input  logic                            d_ready_i,
  output logic [N_LANES*OUT_WIDTH-1:0]    d_data_o,
  output logic                            busy_o,
  output logic                            done_o,
  output logic [CNT_WIDTH-1:0]            cnt_o
);

  localparam int unsigned PROD_WIDTH  = 2 * DATA_WIDTH;
  localparam int unsigned SHIFT_WIDTH = $clog2(ACC_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_OUT
  } state_e;

  state_e                        state_q, state_d;
  logic [CNT_WIDTH-1:0]          len_q;
  logic [SHIFT_WIDTH-1:0]        shift_q;
  logic [CNT_WIDTH-1:0]          cnt_q;
  logic signed [PROD_WIDTH-1:0]  prod_q [N_LANES];
  logic                          prod_valid_q;
  logic signed [ACC_WIDTH-1:0]   acc_q  [N_LANES];
  logic                          done_q;

  logic start_fire;
  logic beat_fire;
  logic beats_left;

  // Full-width signed lane product: both operands are sign-extended to the
  // product width first, so the low PROD_WIDTH bits are the exact product.
  function automatic logic signed [PROD_WIDTH-1:0] lane_mul(
    input logic signed [DATA_WIDTH-1:0] x,
    input logic signed [DATA_WIDTH-1:0] y
  );
    logic signed [PROD_WIDTH-1:0] xe;
    logic signed [PROD_WIDTH-1:0] ye;
    xe = {{DATA_WIDTH{x[DATA_WIDTH-1]}}, x};
    ye = {{DATA_WIDTH{y[DATA_WIDTH-1]}}, y};
    return xe * ye;
  endfunction

  // A beat moves only when both streams are valid. Each ready depends on the
  // other stream's valid, so neither stream is ever consumed on its own.
  assign beats_left = (cnt_q < len_q);
  assign a_ready_o  = (state_q == ST_ACC) && b_valid_i && beats_left;
  assign b_ready_o  = (state_q == ST_ACC) && a_valid_i && beats_left;
  assign beat_fire  = (state_q == ST_ACC) && a_valid_i && b_valid_i && beats_left;
  assign start_fire = (state_q == ST_IDLE) && start_i && !clear_i;

  assign d_valid_o = (state_q == ST_OUT);
  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = done_q;
  assign cnt_o     = cnt_q;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. ACC is left only after the last product has drained
  // into the accumulators. A job with zero beats goes straight to OUT.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = (len_i == '0) ? ST_OUT : ST_ACC;
        end
      end
      ST_ACC: begin
        if ((cnt_q == len_q) && !prod_valid_q) begin
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (d_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (clear_i) begin
      state_d = ST_IDLE;
    end
  end

  // Job parameters, beat counter and the two-stage MAC pipeline.
  // Stage 1 registers the lane products. Stage 2 folds them into the
  // accumulators, which wrap on overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_q        <= '0;
      shift_q      <= '0;
      cnt_q        <= '0;
      prod_valid_q <= 1'b0;
      done_q       <= 1'b0;
      for (int i = 0; i < N_LANES; i++) begin
        prod_q[i] <= '0;
        acc_q[i]  <= '0;
      end
    end else if (clear_i) begin
      len_q        <= '0;
      shift_q      <= '0;
      cnt_q        <= '0;
      prod_valid_q <= 1'b0;
      done_q       <= 1'b0;
      for (int i = 0; i < N_LANES; i++) begin
        prod_q[i] <= '0;
        acc_q[i]  <= '0;
      end
    end else begin
      done_q <= (state_q == ST_OUT) && d_ready_i;
      if (start_fire) begin
        len_q        <= len_i;
        shift_q      <= shift_i;
        cnt_q        <= '0;
        prod_valid_q <= 1'b0;
        for (int i = 0; i < N_LANES; i++) begin
          acc_q[i] <= '0;
        end
      end else begin
        prod_valid_q <= beat_fire;
        if (beat_fire) begin
          cnt_q <= cnt_q + CNT_WIDTH'(1);
          for (int i = 0; i < N_LANES; i++) begin
            prod_q[i] <= lane_mul(a_data_i[i*DATA_WIDTH +: DATA_WIDTH],
                                  b_data_i[i*DATA_WIDTH +: DATA_WIDTH]);
          end
        end
        if (prod_valid_q) begin
          for (int i = 0; i < N_LANES; i++) begin
            acc_q[i] <= acc_q[i] +
                        {{(ACC_WIDTH-PROD_WIDTH){prod_q[i][PROD_WIDTH-1]}}, prod_q[i]};
          end
        end
      end
    end
  end

`ifdef MAC_ENGINE_NLANE_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  // Result formatting with clamping. The accumulators are frozen during OUT,
  // so the result holds steady under backpressure.
  always_comb begin
    logic signed [ACC_WIDTH-1:0] shifted;
    d_data_o = '0;
    shifted  = '0;
    if (state_q == ST_OUT) begin
      for (int i = 0; i < N_LANES; i++) begin
        shifted = acc_q[i] >>> shift_q;
        if (shifted > SAT_MAX) begin
          d_data_o[i*OUT_WIDTH +: OUT_WIDTH] = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
          d_data_o[i*OUT_WIDTH +: OUT_WIDTH] = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end else begin
          d_data_o[i*OUT_WIDTH +: OUT_WIDTH] = shifted[OUT_WIDTH-1:0];
        end
      end
    end
  end
`else
  // Result formatting with wrap. The accumulators are frozen during OUT, so
  // the result holds steady under backpressure.
  always_comb begin
    d_data_o = '0;
    if (state_q == ST_OUT) begin
      for (int i = 0; i < N_LANES; i++) begin
        d_data_o[i*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(acc_q[i] >>> shift_q);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mac_engine_nlane.sv
// ---------------------------------------------------------------------------
// tb_mac_engine_nlane
//
// Directed bench for mac_engine_nlane with the default parameters. Each task
// exercises one scenario and compares the outputs against hand-computed
// constants. It follows the build's MAC_ENGINE_NLANE_SAT_EN setting.
// ---------------------------------------------------------------------------
module tb_mac_engine_nlane;

  localparam int NL = 4;
  localparam int DW = 16;
  localparam int AW = 40;
  localparam int OW = 32;
  localparam int CW = 16;
  localparam int SW = $clog2(AW);

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic                clear_i = 1'b0;
  logic                start_i = 1'b0;
  logic [CW-1:0]       len_i = '0;
  logic [SW-1:0]       shift_i = '0;
  logic                a_valid_i = 1'b0;
  logic                a_ready_o;
  logic [NL*DW-1:0]    a_data_i = '0;
  logic                b_valid_i = 1'b0;
  logic                b_ready_o;
  logic [NL*DW-1:0]    b_data_i = '0;
  logic                d_valid_o;
  logic                d_ready_i = 1'b0;
  logic [NL*OW-1:0]    d_data_o;
  logic                busy_o;
  logic                done_o;
  logic [CW-1:0]       cnt_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  mac_engine_nlane #(
    .N_LANES(NL), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .start_i(start_i), .len_i(len_i), .shift_i(shift_i),
    .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_data_i(a_data_i),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_data_i(b_data_i),
    .d_valid_o(d_valid_o), .d_ready_i(d_ready_i), .d_data_o(d_data_o),
    .busy_o(busy_o), .done_o(done_o), .cnt_o(cnt_o)
  );

  function automatic logic [NL*DW-1:0] rep16(input logic [DW-1:0] x);
    return {x, x, x, x};
  endfunction

  function automatic logic [NL*OW-1:0] rep32(input logic [OW-1:0] x);
    return {x, x, x, x};
  endfunction

  // Pulse start_i for one cycle; returns 1 ns after the start edge.
  task automatic start_job(input logic [CW-1:0] len, input logic [SW-1:0] shift);
    @(posedge clk_i); #1;
    start_i = 1'b1;
    len_i   = len;
    shift_i = shift;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  // Count negedges until d_valid_o is seen; cycles = bound+1 on timeout.
  task automatic wait_dvalid(input int bound, output int cycles);
    cycles = 0;
    while (cycles <= bound) begin
      @(negedge clk_i);
      cycles++;
      if (d_valid_o) break;
    end
  endtask

  // Hold d_ready_i for one edge; returns 1 ns after the accepting edge.
  task automatic accept_result();
    d_ready_i = 1'b1;
    @(posedge clk_i); #1;
    d_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni    = 1'b0;
    a_valid_i = 1'b1;
    b_valid_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if (d_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_d_valid: got %b want 0", d_valid_o); end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy_o); end
    checks++;
    if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", done_o); end
    checks++;
    if (cnt_o !== '0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d want 0", cnt_o); end
    checks++;
    if ({a_ready_o, b_ready_o} !== 2'b00) begin errors++; $display("[TB] FAIL reset_ready: got %b want 00", {a_ready_o, b_ready_o}); end
    checks++;
    if (d_data_o !== '0) begin errors++; $display("[TB] FAIL reset_data: got %h want 0", d_data_o); end
    @(posedge clk_i); #1;
    rst_ni    = 1'b1;
    a_valid_i = 1'b0;
    b_valid_i = 1'b0;
  endtask

  task automatic test_basic();
    int cyc;
    a_data_i  = rep16(16'd3);
    b_data_i  = rep16(16'd5);
    a_valid_i = 1'b1;
    b_valid_i = 1'b1;
    start_job(16'd4, 6'd0);
    wait_dvalid(20, cyc);
    checks++;
    if (cyc !== 7) begin errors++; $display("[TB] FAIL basic_latency: got %0d want 7", cyc); end
    checks++;
    if (d_data_o !== rep32(32'd60)) begin errors++; $display("[TB] FAIL basic_data: got %h want %h", d_data_o, rep32(32'd60)); end
    checks++;
    if (cnt_o !== 16'd4) begin errors++; $display("[TB] FAIL basic_cnt: got %0d want 4", cnt_o); end
    checks++;
    if ({busy_o, a_ready_o, b_ready_o, done_o} !== 4'b1000) begin
      errors++; $display("[TB] FAIL basic_out_flags: got %b want 1000", {busy_o, a_ready_o, b_ready_o, done_o});
    end
    accept_result();
    @(negedge clk_i);
    checks++;
    if ({done_o, busy_o, d_valid_o} !== 3'b100) begin
      errors++; $display("[TB] FAIL basic_done: got %b want 100", {done_o, busy_o, d_valid_o});
    end
    @(negedge clk_i);
    checks++;
    if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_pulse: got %b want 0", done_o); end
    a_valid_i = 1'b0;
    b_valid_i = 1'b0;
  endtask

  task automatic test_negative();
    int  cyc;
    bit  lone;
    bit  seen;
    a_data_i  = rep16(16'hFFFE);
    b_data_i  = rep16(16'd7);
    a_valid_i = 1'b1;
    b_valid_i = 1'b1;
    start_job(16'd3, 6'd0);
    wait_dvalid(20, cyc);
    checks++;
    if (cyc !== 6) begin errors++; $display("[TB] FAIL neg_latency: got %0d want 6", cyc); end
    checks++;
    if (d_data_o !== rep32(32'hFFFFFFD6)) begin errors++; $display("[TB] FAIL neg_data: got %h want %h", d_data_o, rep32(32'hFFFFFFD6)); end
    accept_result();
    a_valid_i = 1'b0;
    b_valid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (done_o !== 1'b1) begin errors++; $display("[TB] FAIL neg_done: got %b want 1", done_o); end

    // Same job with independent random valid gaps on a and b.
    lone = 1'b0;
    seen = 1'b0;
    start_job(16'd3, 6'd0);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk_i); #1;
      a_valid_i = 1'($urandom_range(0, 1));
      b_valid_i = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      if ((a_valid_i && a_ready_o) != (b_valid_i && b_ready_o)) lone = 1'b1;
      if (d_valid_o) begin
        seen = 1'b1;
        break;
      end
    end
    a_valid_i = 1'b0;
    b_valid_i = 1'b0;
    checks++;
    if (seen !== 1'b1) begin errors++; $display("[TB] FAIL gaps_timeout: got d_valid %b want 1", seen); end
    checks++;
    if (lone !== 1'b0) begin errors++; $display("[TB] FAIL gaps_lone_consume: got %b want 0", lone); end
    checks++;
    if (d_data_o !== rep32(32'hFFFFFFD6)) begin errors++; $display("[TB] FAIL gaps_data: got %h want %h", d_data_o, rep32(32'hFFFFFFD6)); end
    checks++;
    if (cnt_o !== 16'd3) begin errors++; $display("[TB] FAIL gaps_cnt: got %0d want 3", cnt_o); end
    accept_result();
    @(negedge clk_i);
  endtask

  task automatic test_backpressure();
    int               cyc;
    logic [NL*OW-1:0] expd;
    bit               stable;
    bit               held;
    // Lanes 0..3: a = 1,2,3,4  b = 5,-6,7,-8, two beats.
    expd      = {32'hFFFFFFC0, 32'd42, 32'hFFFFFFE8, 32'd10};
    a_data_i  = {16'd4, 16'd3, 16'd2, 16'd1};
    b_data_i  = {16'hFFF8, 16'h0007, 16'hFFFA, 16'h0005};
    a_valid_i = 1'b1;
    b_valid_i = 1'b1;
    start_job(16'd2, 6'd0);
    wait_dvalid(20, cyc);
    a_valid_i = 1'b0;
    b_valid_i = 1'b0;
    checks++;
    if (cyc !== 5) begin errors++; $display("[TB] FAIL bp_latency: got %0d want 5", cyc); end
    checks++;
    if (d_data_o !== expd) begin errors++; $display("[TB] FAIL bp_lane_data: got %h want %h", d_data_o, expd); end
    stable = 1'b1;
    held   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      if (d_data_o !== expd) stable = 1'b0;
      if ({d_valid_o, busy_o, done_o} !== 3'b110) held = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin errors++; $display("[TB] FAIL bp_stable: got %b want 1", stable); end
    checks++;
    if (held !== 1'b1) begin errors++; $display("[TB] FAIL bp_held: got %b want 1", held); end
    accept_result();
    @(negedge clk_i);
    checks++;
    if ({done_o, busy_o} !== 2'b10) begin errors++; $display("[TB] FAIL bp_done: got %b want 10", {done_o, busy_o}); end
  endtask

  task automatic test_saturation();
    logic [CW-1:0]    lens   [4];
    logic [SW-1:0]    shifts [4];
    logic [NL*DW-1:0] avec   [4];
    logic [NL*OW-1:0] expd   [4];
    int               cyc;
    // Lanes 0,1 accumulate 0x7FFF*0x7FFF; lanes 2,3 accumulate 0x8000*0x7FFF.
    lens[0] = 16'd4; shifts[0] = 6'd0; avec[0] = 64'h8000_8000_7FFF_7FFF;
`ifdef MAC_ENGINE_NLANE_SAT_EN
    expd[0] = {32'h80000000, 32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF};
`else
    expd[0] = {32'h00020000, 32'h00020000, 32'hFFFC0004, 32'hFFFC0004};
`endif
    lens[1] = 16'd4; shifts[1] = 6'd4; avec[1] = 64'h8000_8000_7FFF_7FFF;
    expd[1] = {32'hF0002000, 32'hF0002000, 32'h0FFFC000, 32'h0FFFC000};
    // Two beats of 0x3FFF0001 give 0x7FFE0002, shifted by 4 gives 0x07FFE000.
    lens[2] = 16'd2; shifts[2] = 6'd4; avec[2] = rep16(16'h7FFF);
    expd[2] = rep32(32'h07FFE000);
    lens[3] = 16'd4; shifts[3] = 6'd0; avec[3] = rep16(16'h7FFF);
`ifdef MAC_ENGINE_NLANE_SAT_EN
    expd[3] = rep32(32'h7FFFFFFF);
`else
    expd[3] = rep32(32'hFFFC0004);
`endif
    b_data_i = rep16(16'h7FFF);
    for (int j = 0; j < 4; j++) begin
      a_data_i  = avec[j];
      a_valid_i = 1'b1;
      b_valid_i = 1'b1;
      start_job(lens[j], shifts[j]);
      wait_dvalid(20, cyc);
      a_valid_i = 1'b0;
      b_valid_i = 1'b0;
      checks++;
      if (d_data_o !== expd[j]) begin errors++; $display("[TB] FAIL sat_job%0d: got %h want %h", j, d_data_o, expd[j]); end
      accept_result();
      @(negedge clk_i);
    end
  endtask

  task automatic test_clear();
    int cyc;
    bit quiet;
    a_data_i  = rep16(16'd1);
    b_data_i  = rep16(16'd1);
    a_valid_i = 1'b1;
    b_valid_i = 1'b1;
    start_job(16'd8, 6'd0);
    @(posedge clk_i);
    @(posedge clk_i); #1;
    clear_i   = 1'b1;
    a_valid_i = 1'b0;
    b_valid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (cnt_o !== 16'd2) begin errors++; $display("[TB] FAIL clear_pre_cnt: got %0d want 2", cnt_o); end
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({busy_o, cnt_o} !== {1'b0, 16'd0}) begin errors++; $display("[TB] FAIL clear_idle: got busy %b cnt %0d want 0 0", busy_o, cnt_o); end
    quiet = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (d_valid_o || done_o || busy_o) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) begin errors++; $display("[TB] FAIL clear_quiet: got %b want 1", quiet); end

    // start and clear in the same cycle: clear wins, engine stays idle.
    @(posedge clk_i); #1;
    start_i = 1'b1; clear_i = 1'b1; len_i = 16'd1;
    @(posedge clk_i); #1;
    start_i = 1'b0; clear_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL clear_beats_start: got busy %b want 0", busy_o); end

    a_valid_i = 1'b1;
    b_valid_i = 1'b1;
    start_job(16'd1, 6'd0);
    wait_dvalid(20, cyc);
    a_valid_i = 1'b0;
    b_valid_i = 1'b0;
    checks++;
    if (cyc !== 4) begin errors++; $display("[TB] FAIL clear_next_latency: got %0d want 4", cyc); end
    checks++;
    if (d_data_o !== rep32(32'd1)) begin errors++; $display("[TB] FAIL clear_next_data: got %h want %h", d_data_o, rep32(32'd1)); end
    accept_result();
    @(negedge clk_i);
  endtask

  task automatic test_len_zero();
    int cyc;
    a_data_i  = rep16(16'd9);
    b_data_i  = rep16(16'd9);
    a_valid_i = 1'b1;
    b_valid_i = 1'b1;
    start_job(16'd0, 6'd0);
    wait_dvalid(20, cyc);
    checks++;
    if (cyc !== 1) begin errors++; $display("[TB] FAIL len0_latency: got %0d want 1", cyc); end
    checks++;
    if ({a_ready_o, b_ready_o, cnt_o} !== {2'b00, 16'd0}) begin
      errors++; $display("[TB] FAIL len0_no_consume: got ready %b cnt %0d want 00 0", {a_ready_o, b_ready_o}, cnt_o);
    end
    checks++;
    if (d_data_o !== '0) begin errors++; $display("[TB] FAIL len0_data: got %h want 0", d_data_o); end
    accept_result();
    @(negedge clk_i);
    checks++;
    if (done_o !== 1'b1) begin errors++; $display("[TB] FAIL len0_done: got %b want 1", done_o); end

    // A second start during ACC (with different len/shift) must be ignored.
    a_data_i = rep16(16'd2);
    b_data_i = rep16(16'd2);
    start_job(16'd3, 6'd0);
    start_i = 1'b1; len_i = 16'd0; shift_i = 6'd1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    wait_dvalid(20, cyc);
    a_valid_i = 1'b0;
    b_valid_i = 1'b0;
    checks++;
    if (cyc !== 5) begin errors++; $display("[TB] FAIL busy_start_latency: got %0d want 5", cyc); end
    checks++;
    if ({d_data_o, cnt_o} !== {rep32(32'd12), 16'd3}) begin
      errors++; $display("[TB] FAIL busy_start_result: got %h cnt %0d want %h cnt 3", d_data_o, cnt_o, rep32(32'd12));
    end
    accept_result();
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit quiet;
    a_data_i  = rep16(16'd1);
    b_data_i  = rep16(16'd1);
    a_valid_i = 1'b1;
    b_valid_i = 1'b1;
    start_job(16'd8, 6'd0);
    @(posedge clk_i);
    @(posedge clk_i); #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({busy_o, d_valid_o, a_ready_o, cnt_o} !== {3'b000, 16'd0}) begin
      errors++; $display("[TB] FAIL rstmid_abort: got busy %b dv %b ardy %b cnt %0d want all 0", busy_o, d_valid_o, a_ready_o, cnt_o);
    end
    @(posedge clk_i); #1;
    rst_ni    = 1'b1;
    a_valid_i = 1'b0;
    b_valid_i = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      if (done_o || d_valid_o || busy_o) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_quiet: got %b want 1", quiet); end
    a_valid_i = 1'b1;
    b_valid_i = 1'b1;
    start_job(16'd1, 6'd0);
    wait_dvalid(20, cyc);
    a_valid_i = 1'b0;
    b_valid_i = 1'b0;
    checks++;
    if (d_data_o !== rep32(32'd1)) begin errors++; $display("[TB] FAIL rstmid_next_data: got %h want %h", d_data_o, rep32(32'd1)); end
    accept_result();
    @(negedge clk_i);
  endtask

  initial begin
    $display("[TB] mac_engine_nlane directed bench");
    test_reset();
    test_basic();
    test_negative();
    test_backpressure();
    test_saturation();
    test_clear();
    test_len_zero();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
